// File: rtl/drive_cmd_uart_tx.sv
// Drive Direct command serialiser: turns the mode FSM's 3-bit drive_state into
// 5-byte 0x91 frames and shifts them out as UART 8N1, on change and on periodic refresh.
module drive_cmd_uart_tx #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int REFRESH_CYCLES = 5_000_000,
  parameter int TURN_MMS       = 100,
  parameter int SLOW_MMS       = 100,
  parameter int MED_MMS        = 200,
  parameter int FAST_MMS       = 300
) (
  input  logic       clk_50,
  input  logic       reset,
  input  logic [2:0] drive_state,
  output logic       uart_tx,
  output logic       busy,
  output logic       frame_done,
  output logic [2:0] sent_state
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(REFRESH_CYCLES - 1);
  localparam logic [7:0]       OPCODE   = 8'h91;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           r_state, w_stateNext;
  logic [CNT_W-1:0] r_bitCnt, w_bitCntNext;
  logic [2:0]       r_bitIdx, w_bitIdxNext;
  logic [2:0]       r_byteIdx, w_byteIdxNext;
  logic [39:0]      r_frame, w_frameNext;
  logic [7:0]       r_txByte, w_txByteNext;
  logic [TMR_W-1:0] r_refreshTmr, w_refreshTmrNext;
  logic             r_firstFrame, w_firstFrameNext;
  logic             r_tx, w_txNext;
  logic             r_busy, w_busyNext;
  logic             r_frameDone, w_frameDoneNext;
  logic [2:0]       r_sentState, w_sentStateNext;

  logic             w_refreshDue;
  logic             w_trigger;
  logic             w_bitEnd;
  logic [15:0]      w_velRight;
  logic [15:0]      w_velLeft;

  // Wheel velocities (right, left); unused codes 110/111 fall through to STOP.
  always_comb begin
    w_velRight = '0;
    w_velLeft  = '0;
    case (drive_state)
      3'b001: begin
        w_velRight = 16'(TURN_MMS);
        w_velLeft  = -16'(TURN_MMS);
      end
      3'b010: begin
        w_velRight = -16'(TURN_MMS);
        w_velLeft  = 16'(TURN_MMS);
      end
      3'b011: begin
        w_velRight = 16'(SLOW_MMS);
        w_velLeft  = 16'(SLOW_MMS);
      end
      3'b100: begin
        w_velRight = 16'(MED_MMS);
        w_velLeft  = 16'(MED_MMS);
      end
      3'b101: begin
        w_velRight = 16'(FAST_MMS);
        w_velLeft  = 16'(FAST_MMS);
      end
      default: begin
        w_velRight = '0;
        w_velLeft  = '0;
      end
    endcase
  end

  assign w_refreshDue = (r_refreshTmr == TMR_LAST);
  assign w_trigger    = r_firstFrame | (drive_state != r_sentState) | w_refreshDue;
  assign w_bitEnd     = (r_bitCnt == BIT_LAST);

  // Next-state and datapath; the frame snapshot is taken only at the IDLE trigger,
  // so drive_state changes mid-frame never reach the bytes in flight.
  always_comb begin
    w_stateNext      = r_state;
    w_bitCntNext     = w_bitEnd ? '0 : r_bitCnt + 1'b1;
    w_bitIdxNext     = r_bitIdx;
    w_byteIdxNext    = r_byteIdx;
    w_frameNext      = r_frame;
    w_txByteNext     = r_txByte;
    w_refreshTmrNext = w_refreshDue ? r_refreshTmr : r_refreshTmr + 1'b1;
    w_firstFrameNext = r_firstFrame;
    w_txNext         = r_tx;
    w_busyNext       = r_busy;
    w_frameDoneNext  = 1'b0;
    w_sentStateNext  = r_sentState;

    case (r_state)
      ST_IDLE: begin
        w_bitCntNext = '0;
        if (w_trigger) begin
          w_stateNext      = ST_START;
          w_sentStateNext  = drive_state;
          w_frameNext      = {OPCODE, w_velRight, w_velLeft};
          w_firstFrameNext = 1'b0;
          w_refreshTmrNext = '0;
          w_byteIdxNext    = 3'd0;
          w_txNext         = 1'b0;
          w_busyNext       = 1'b1;
        end
      end

      ST_START: begin
        if (w_bitEnd) begin
          w_stateNext  = ST_DATA;
          w_bitIdxNext = 3'd0;
          w_txNext     = r_frame[32];
          w_txByteNext = {1'b0, r_frame[39:33]};
          w_frameNext  = {r_frame[31:0], 8'h00};
        end
      end

      ST_DATA: begin
        if (w_bitEnd) begin
          if (r_bitIdx == 3'd7) begin
            w_stateNext = ST_STOP;
            w_txNext    = 1'b1;
          end else begin
            w_bitIdxNext = r_bitIdx + 3'd1;
            w_txNext     = r_txByte[0];
            w_txByteNext = {1'b0, r_txByte[7:1]};
          end
        end
      end

      ST_STOP: begin
        if (w_bitEnd) begin
          if (r_byteIdx < 3'd4) begin
            w_stateNext   = ST_START;
            w_byteIdxNext = r_byteIdx + 3'd1;
            w_txNext      = 1'b0;
          end else begin
            w_stateNext     = ST_IDLE;
            w_busyNext      = 1'b0;
            w_frameDoneNext = 1'b1;
          end
        end
      end

      default: begin
        w_stateNext = ST_IDLE;
        w_txNext    = 1'b1;
        w_busyNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bitCnt     <= '0;
      r_bitIdx     <= 3'd0;
      r_byteIdx    <= 3'd0;
      r_frame      <= '0;
      r_txByte     <= '0;
      r_refreshTmr <= '0;
      r_firstFrame <= 1'b1;
      r_tx         <= 1'b1;
      r_busy       <= 1'b0;
      r_frameDone  <= 1'b0;
      r_sentState  <= 3'b000;
    end else begin
      r_state      <= w_stateNext;
      r_bitCnt     <= w_bitCntNext;
      r_bitIdx     <= w_bitIdxNext;
      r_byteIdx    <= w_byteIdxNext;
      r_frame      <= w_frameNext;
      r_txByte     <= w_txByteNext;
      r_refreshTmr <= w_refreshTmrNext;
      r_firstFrame <= w_firstFrameNext;
      r_tx         <= w_txNext;
      r_busy       <= w_busyNext;
      r_frameDone  <= w_frameDoneNext;
      r_sentState  <= w_sentStateNext;
    end
  end

  assign uart_tx    = r_tx;
  assign busy       = r_busy;
  assign frame_done = r_frameDone;
  assign sent_state = r_sentState;

endmodule

// File: tb/tb_drive_cmd_uart_tx.sv
// Bench for drive_cmd_uart_tx: decodes the serial line at bit centres and compares each
// frame, its timing and the handshake outputs against a velocity-table reference model.
module tb_drive_cmd_uart_tx;

  localparam int CPB   = 4;
  localparam int REF   = 2000;
  localparam int FRAME = 50 * CPB;

  logic       clk_50 = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] drive_state = 3'b000;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;
  logic [2:0] sent_state;

  int checks = 0;
  int errors = 0;
  int cycle = 0;
  int startCyc = 0;
  int prevStart = 0;
  bit gotStart;
  logic [2:0] modelSent = 3'b000;

  logic [7:0]  rxBytes[5];
  logic [39:0] rxFrame;
  int          rxBusyCnt;
  int          rxDoneCnt;
  int          rxDoneOff;
  bit          rxFramingOk;

  drive_cmd_uart_tx #(
    .CLKS_PER_BIT  (CPB),
    .REFRESH_CYCLES(REF),
    .TURN_MMS      (100),
    .SLOW_MMS      (100),
    .MED_MMS       (200),
    .FAST_MMS      (300)
  ) dut (
    .clk_50     (clk_50),
    .reset      (reset),
    .drive_state(drive_state),
    .uart_tx    (uart_tx),
    .busy       (busy),
    .frame_done (frame_done),
    .sent_state (sent_state)
  );

  always #10 clk_50 = ~clk_50;

  always @(posedge clk_50) cycle <= cycle + 1;

  // Reference: opcode then right and left wheel speeds, big-endian two's complement.
  function automatic logic [39:0] expFrame(input logic [2:0] s);
    int r;
    int l;
    logic [15:0] rv;
    logic [15:0] lv;
    case (s)
      3'd1:    begin r = 100;  l = -100; end
      3'd2:    begin r = -100; l = 100;  end
      3'd3:    begin r = 100;  l = 100;  end
      3'd4:    begin r = 200;  l = 200;  end
      3'd5:    begin r = 300;  l = 300;  end
      default: begin r = 0;    l = 0;    end
    endcase
    rv = 16'(r);
    lv = 16'(l);
    return {8'h91, rv, lv};
  endfunction

  task automatic wait_start(input int budget);
    gotStart = 1'b0;
    for (int i = 0; i < budget && !gotStart; i++) begin
      @(negedge clk_50);
      if (uart_tx === 1'b0) begin
        gotStart = 1'b1;
        startCyc = cycle;
      end
    end
  endtask

  // Called on the first negedge with the start bit low; ends on the frame_done negedge.
  task automatic capture_frame();
    int bp;
    int b;
    int j;
    rxFramingOk = 1'b1;
    rxBusyCnt   = 0;
    rxDoneCnt   = 0;
    rxDoneOff   = -1;
    for (int o = 0; o <= FRAME; o++) begin
      if (o > 0) @(negedge clk_50);
      if (busy === 1'b1) rxBusyCnt++;
      if (frame_done === 1'b1) begin
        rxDoneCnt++;
        rxDoneOff = o;
      end
      if ((o % CPB) == CPB / 2 && o < FRAME) begin
        bp = o / CPB;
        b  = bp / 10;
        j  = bp % 10;
        if (j == 0) begin
          if (uart_tx !== 1'b0) rxFramingOk = 1'b0;
        end else if (j == 9) begin
          if (uart_tx !== 1'b1) rxFramingOk = 1'b0;
        end else begin
          rxBytes[b][j-1] = uart_tx;
        end
      end
    end
    rxFrame = {rxBytes[0], rxBytes[1], rxBytes[2], rxBytes[3], rxBytes[4]};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_state = 3'b000;
    repeat (3) @(negedge clk_50);
    checks++;
    if (uart_tx !== 1'b1) begin errors++; $display("[TB] FAIL reset_tx: got %b expected 1", uart_tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", frame_done); end
    checks++;
    if (sent_state !== 3'b000) begin errors++; $display("[TB] FAIL reset_sent: got %b expected 000", sent_state); end
  endtask

  task automatic test_first_frame();
    int relCyc;
    relCyc = cycle;
    reset = 1'b0;
    wait_start(20);
    checks++;
    if (!gotStart || startCyc != relCyc + 1) begin
      errors++; $display("[TB] FAIL first_latency: got start %0d (seen %0b) expected %0d", startCyc, gotStart, relCyc + 1);
    end
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(3'd0)) begin errors++; $display("[TB] FAIL first_bytes: got %h expected %h", rxFrame, expFrame(3'd0)); end
    checks++;
    if (rxBusyCnt != FRAME || !rxFramingOk) begin
      errors++; $display("[TB] FAIL first_busy: busy cycles %0d framing %0b expected %0d and 1", rxBusyCnt, rxFramingOk, FRAME);
    end
    checks++;
    if (rxDoneCnt != 1 || rxDoneOff != FRAME) begin
      errors++; $display("[TB] FAIL first_done: pulses %0d at %0d expected 1 at %0d", rxDoneCnt, rxDoneOff, FRAME);
    end
    modelSent = 3'd0;
    prevStart = startCyc;
  endtask

  task automatic test_directed_states();
    logic [2:0] seq[3];
    int chg;
    seq[0] = 3'd5;
    seq[1] = 3'd1;
    seq[2] = 3'd2;
    for (int n = 0; n < 3; n++) begin
      chg = cycle;
      drive_state = seq[n];
      wait_start(20);
      checks++;
      if (!gotStart || startCyc != chg + 1) begin
        errors++; $display("[TB] FAIL change_latency_%0d: got start %0d expected %0d", seq[n], startCyc, chg + 1);
      end
      capture_frame();
      checks++;
      if (rxFrame !== expFrame(seq[n])) begin
        errors++; $display("[TB] FAIL state_bytes_%0d: got %h expected %h", seq[n], rxFrame, expFrame(seq[n]));
      end
      checks++;
      if (sent_state !== seq[n]) begin errors++; $display("[TB] FAIL state_sent_%0d: got %b expected %b", seq[n], sent_state, seq[n]); end
      checks++;
      if (rxBusyCnt != FRAME || !rxFramingOk || rxDoneCnt != 1 || rxDoneOff != FRAME) begin
        errors++; $display("[TB] FAIL state_handshake_%0d: busy %0d framing %0b done %0d@%0d expected %0d 1 1@%0d",
                           seq[n], rxBusyCnt, rxFramingOk, rxDoneCnt, rxDoneOff, FRAME, FRAME);
      end
      modelSent = seq[n];
      prevStart = startCyc;
    end
  endtask

  task automatic test_toggle_midframe();
    drive_state = 3'd3;
    wait_start(20);
    fork
      capture_frame();
      begin
        repeat (40) @(negedge clk_50);
        drive_state = 3'd4;
        repeat (40) @(negedge clk_50);
        drive_state = 3'd3;
      end
    join
    checks++;
    if (rxFrame !== expFrame(3'd3)) begin errors++; $display("[TB] FAIL toggle_bytes: got %h expected %h", rxFrame, expFrame(3'd3)); end
    prevStart = startCyc;
    wait_start(REF + 50);
    checks++;
    if (!gotStart || startCyc != prevStart + REF) begin
      errors++; $display("[TB] FAIL toggle_refresh_time: got start %0d expected %0d", startCyc, prevStart + REF);
    end
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(3'd3)) begin errors++; $display("[TB] FAIL toggle_refresh_bytes: got %h expected %h", rxFrame, expFrame(3'd3)); end
    modelSent = 3'd3;
    prevStart = startCyc;
  endtask

  task automatic test_state7_refresh();
    drive_state = 3'd7;
    wait_start(20);
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(3'd7)) begin errors++; $display("[TB] FAIL s7_bytes: got %h expected %h", rxFrame, expFrame(3'd7)); end
    checks++;
    if (sent_state !== 3'd7) begin errors++; $display("[TB] FAIL s7_sent: got %b expected 111", sent_state); end
    prevStart = startCyc;
    wait_start(REF + 50);
    checks++;
    if (!gotStart || startCyc != prevStart + REF) begin
      errors++; $display("[TB] FAIL s7_refresh_time: got start %0d expected %0d", startCyc, prevStart + REF);
    end
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(3'd7)) begin errors++; $display("[TB] FAIL s7_refresh_bytes: got %h expected %h", rxFrame, expFrame(3'd7)); end
    modelSent = 3'd7;
    prevStart = startCyc;
  endtask

  task automatic test_change_at_refresh();
    while (cycle < prevStart + REF - 1) @(negedge clk_50);
    drive_state = 3'd4;
    wait_start(20);
    checks++;
    if (!gotStart || startCyc != prevStart + REF) begin
      errors++; $display("[TB] FAIL coincide_time: got start %0d expected %0d", startCyc, prevStart + REF);
    end
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(3'd4)) begin errors++; $display("[TB] FAIL coincide_bytes: got %h expected %h", rxFrame, expFrame(3'd4)); end
    prevStart = startCyc;
    wait_start(REF + 50);
    checks++;
    if (!gotStart || startCyc != prevStart + REF) begin
      errors++; $display("[TB] FAIL coincide_no_extra: got start %0d expected %0d", startCyc, prevStart + REF);
    end
    capture_frame();
    modelSent = 3'd4;
    prevStart = startCyc;
  endtask

  task automatic test_random_midframe();
    logic [2:0] expState;
    int expStart;
    int nChg;
    for (int it = 0; it < 8; it++) begin
      expState = drive_state;
      expStart = (expState != modelSent) ? cycle + 1 : prevStart + REF;
      wait_start(REF + 50);
      checks++;
      if (!gotStart || startCyc != expStart) begin
        errors++; $display("[TB] FAIL rand%0d_time: got start %0d expected %0d", it, startCyc, expStart);
      end
      nChg = $urandom_range(0, 3);
      fork
        capture_frame();
        begin
          for (int k = 0; k < nChg; k++) begin
            repeat ($urandom_range(1, 40)) @(negedge clk_50);
            drive_state = 3'($urandom_range(0, 7));
          end
        end
      join
      checks++;
      if (rxFrame !== expFrame(expState)) begin
        errors++; $display("[TB] FAIL rand%0d_bytes: got %h expected %h", it, rxFrame, expFrame(expState));
      end
      checks++;
      if (sent_state !== expState) begin errors++; $display("[TB] FAIL rand%0d_sent: got %b expected %b", it, sent_state, expState); end
      checks++;
      if (rxBusyCnt != FRAME || !rxFramingOk || rxDoneCnt != 1 || rxDoneOff != FRAME) begin
        errors++; $display("[TB] FAIL rand%0d_handshake: busy %0d framing %0b done %0d@%0d expected %0d 1 1@%0d",
                           it, rxBusyCnt, rxFramingOk, rxDoneCnt, rxDoneOff, FRAME, FRAME);
      end
      modelSent = expState;
      prevStart = startCyc;
    end
  endtask

  task automatic test_reset_midframe();
    logic [2:0] s;
    int doneSeen;
    int relCyc;
    s = 3'($urandom_range(1, 5));
    if (s == modelSent) s = (s == 3'd5) ? 3'd1 : s + 3'd1;
    drive_state = s;
    wait_start(REF + 50);
    repeat (90) @(negedge clk_50);
    reset = 1'b1;
    @(negedge clk_50);
    checks++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL midreset_line: tx %b busy %b expected 1 0", uart_tx, busy);
    end
    checks++;
    if (sent_state !== 3'b000) begin errors++; $display("[TB] FAIL midreset_sent: got %b expected 000", sent_state); end
    doneSeen = (frame_done === 1'b1) ? 1 : 0;
    repeat (4) begin
      @(negedge clk_50);
      if (frame_done === 1'b1) doneSeen++;
    end
    checks++;
    if (doneSeen != 0) begin errors++; $display("[TB] FAIL midreset_done: got %0d pulses expected 0", doneSeen); end
    relCyc = cycle;
    reset = 1'b0;
    wait_start(20);
    checks++;
    if (!gotStart || startCyc != relCyc + 1) begin
      errors++; $display("[TB] FAIL midreset_restart: got start %0d expected %0d", startCyc, relCyc + 1);
    end
    capture_frame();
    checks++;
    if (rxFrame !== expFrame(s)) begin errors++; $display("[TB] FAIL midreset_bytes: got %h expected %h", rxFrame, expFrame(s)); end
    checks++;
    if (sent_state !== s || rxDoneCnt != 1) begin
      errors++; $display("[TB] FAIL midreset_sent_after: sent %b done %0d expected %b 1", sent_state, rxDoneCnt, s);
    end
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_directed_states();
    test_toggle_midframe();
    test_state7_refresh();
    test_change_at_refresh();
    test_random_midframe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #4_000_000;
    $display("[TB] FAIL watchdog: cycle %0d reached without completion, expected finish earlier", cycle);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
